// File: rtl/chip8_keypad.sv
// 4x4 CHIP-8 hex keypad scanner with per-key debounce and a one-cycle key event.
// Define CHIP8_KEYPAD_RELEASE_EVENT_EN to raise key_event on release instead of press.
module chip8_keypad #(
   parameter int SCAN_DIV       = 25_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic [15:0] keys,
   output logic        key_event,
   output logic [3:0]  key_code
);

   localparam int                 DWELL_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   // cnt+1 == DEBOUNCE_SCANS is tested as cnt == DEBOUNCE_SCANS-1 to stay in 4 bits
   localparam logic [3:0]         CNT_LAST   = 4'(DEBOUNCE_SCANS - 1);

   function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hC;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hD;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hE;
         4'b11_00: k = 4'hA;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hB;
         default:  k = 4'hF;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] lowest_key(input logic [15:0] mask);
      logic [3:0] k;
      k = 4'h0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) k = 4'(i);
      end
      return k;
   endfunction

   logic [3:0]         row_p0;
   logic [3:0]         row_p1;
   logic [DWELL_W-1:0] dwell;
   logic [1:0]         col_idx;
   logic               sample;
   logic [3:0]         cnt     [16];
   logic [3:0]         cnt_nxt [16];
   logic [15:0]        keys_nxt;
   logic [15:0]        evt_mask;

   assign sample = (dwell == DWELL_LAST);

   // Debounce evaluation for the four keys of the driven column on its sample cycle
   always_comb begin
      logic [3:0] k;
      logic       raw;
      k        = 4'h0;
      raw      = 1'b0;
      keys_nxt = keys;
      cnt_nxt  = cnt;
      evt_mask = '0;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            k   = key_at(2'(r), col_idx);
            raw = ~row_p1[r];
            if (raw == keys[k]) begin
               cnt_nxt[k] = 4'h0;
            end else if (cnt[k] == CNT_LAST) begin
               cnt_nxt[k]  = 4'h0;
               keys_nxt[k] = raw;
`ifdef CHIP8_KEYPAD_RELEASE_EVENT_EN
               evt_mask[k] = ~raw;
`else
               evt_mask[k] = raw;
`endif
            end else begin
               cnt_nxt[k] = cnt[k] + 4'h1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_p0    <= 4'hF;
         row_p1    <= 4'hF;
         dwell     <= '0;
         col_idx   <= 2'd0;
         col_out   <= 4'b1110;
         keys      <= '0;
         key_event <= 1'b0;
         key_code  <= 4'h0;
         for (int i = 0; i < 16; i++) cnt[i] <= 4'h0;
      end else begin
         // p0/p1: two-flop synchronizer for the asynchronous rows
         row_p0 <= row_in;
         row_p1 <= row_p0;
         if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col_out <= ~(4'b0001 << (col_idx + 2'd1));
         end else begin
            dwell   <= dwell + 1'b1;
         end
         keys      <= keys_nxt;
         cnt       <= cnt_nxt;
         key_event <= |evt_mask;
         if (|evt_mask) key_code <= lowest_key(evt_mask);
      end
   end

endmodule

// File: tb/tb_chip8_keypad.sv
// Randomized and directed bench for chip8_keypad against a cycle-counting reference model.
module tb_chip8_keypad;

   localparam int SD = 8;
   localparam int DB = 3;
`ifdef CHIP8_KEYPAD_RELEASE_EVENT_EN
   localparam int PRESS_EV = 0;
   localparam int REL_EV   = 1;
`else
   localparam int PRESS_EV = 1;
   localparam int REL_EV   = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] keys;
   logic        key_event;
   logic [3:0]  key_code;
   logic [15:0] held = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int ev_cnt = 0;

   int kmap [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

   chip8_keypad #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .row_in    (row_in),
      .col_out   (col_out),
      .keys      (keys),
      .key_event (key_event),
      .key_code  (key_code)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a held key pulls its row low while its column is driven
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (col_out[c] == 1'b0 && held[kmap[r][c]]) row_in[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sample times and columns derived from cycles elapsed since reset
   int          n = 0;
   bit          mvalid = 1'b0;
   logic [15:0] d1, d2, m_keys;
   int          m_cnt [16];
   logic        m_ev;
   logic [3:0]  m_code;

   always @(posedge clk) begin
      int c, k;
      logic [15:0] tog, nk, em;
      if (reset) begin
         n = 0; d1 = '0; d2 = '0; m_keys = '0; m_ev = 1'b0; m_code = 4'h0; mvalid = 1'b1;
         for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      end else begin
         m_ev = 1'b0;
         if (n % SD == SD - 1) begin
            c = (n / SD) % 4;
            tog = '0;
            for (int r = 0; r < 4; r++) begin
               k = kmap[r][c];
               if (d2[k] == m_keys[k]) m_cnt[k] = 0;
               else begin
                  m_cnt[k] = m_cnt[k] + 1;
                  if (m_cnt[k] == DB) begin
                     m_cnt[k] = 0;
                     tog[k] = 1'b1;
                  end
               end
            end
            nk = m_keys ^ tog;
`ifdef CHIP8_KEYPAD_RELEASE_EVENT_EN
            em = tog & ~nk;
`else
            em = tog & nk;
`endif
            if (em != 0) begin
               m_ev = 1'b1;
               for (int i = 15; i >= 0; i--) if (em[i]) m_code = 4'(i);
            end
            m_keys = nk;
         end
         n++;
         d2 = d1;
         d1 = held;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         check("col_out", 32'(col_out), 32'(4'hF ^ (4'd1 << ((n / SD) % 4))));
         check("keys", 32'(keys), 32'(m_keys));
         check("key_event", 32'(key_event), 32'(m_ev));
         check("key_code", 32'(key_code), 32'(m_code));
      end
   end

   always @(posedge clk) if (key_event === 1'b1) ev_cnt++;

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] rot [4];
      int ev0;
      rot = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

      do_reset();
      check("rst_col", 32'(col_out), 32'h0000_000E);
      check("rst_keys", 32'(keys), 32'h0);
      check("rst_event", 32'(key_event), 32'h0);
      for (int i = 0; i < 4; i++) begin
         repeat (SD) @(negedge clk);
         check("rotate", 32'(col_out), 32'(rot[i]));
      end

      ev0 = ev_cnt;
      held = 16'h0004;
      repeat (192) @(negedge clk);
      check("press_keys", 32'(keys), 32'h0004);
      check("press_events", 32'(ev_cnt - ev0), 32'(PRESS_EV));

      ev0 = ev_cnt;
      held = 16'h0000;
      repeat (192) @(negedge clk);
      check("release_keys", 32'(keys), 32'h0);
      check("release_events", 32'(ev_cnt - ev0), 32'(REL_EV));
      check("release_code", 32'(key_code), 32'h2);

      ev0 = ev_cnt;
      for (int f = 0; f < 10; f++) begin
         held = (f % 2 == 0) ? 16'h0004 : 16'h0000;
         repeat (4 * SD) @(negedge clk);
      end
      held = 16'h0000;
      repeat (64) @(negedge clk);
      check("bounce_keys", 32'(keys), 32'h0);
      check("bounce_events", 32'(ev_cnt - ev0), 32'h0);

      ev0 = ev_cnt;
      held = 16'h0402;
      repeat (160) @(negedge clk);
      check("simul_keys", 32'(keys), 32'h0402);
      check("simul_events", 32'(ev_cnt - ev0), 32'(PRESS_EV));
`ifndef CHIP8_KEYPAD_RELEASE_EVENT_EN
      check("simul_code", 32'(key_code), 32'h1);
`endif
      ev0 = ev_cnt;
      held = 16'h0000;
      repeat (160) @(negedge clk);
      check("simul_rel_events", 32'(ev_cnt - ev0), 32'(REL_EV));
      check("simul_rel_code", 32'(key_code), 32'h1);

      do_reset();
      held = 16'h8000;
      repeat (64) @(negedge clk);
      do_reset();
      repeat (90) @(negedge clk);
      check("middeb_early", 32'(keys[15]), 32'h0);
      repeat (10) @(negedge clk);
      check("middeb_set", 32'(keys[15]), 32'h1);
      held = 16'h0000;
      repeat (160) @(negedge clk);

      for (int s = 0; s < 80; s++) begin
         held = 16'($urandom & $urandom & $urandom);
         repeat ($urandom_range(4, 260)) @(negedge clk);
      end
      held = 16'h0000;
      repeat (300) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
